// File: rtl/execute_stage.sv
// MIPS-style execute stage: ALU, branch target, destination select, registered EX/MEM outputs.
// Optional iterative multiply/divide unit with HI/LO is enabled by defining EXECUTE_MULDIV_EN.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rdData1,
    input  logic [31:0] rdData2,
    input  logic [31:0] imm,
    input  logic [8:0]  control,
    input  logic [31:0] PCnextID,
    input  logic [4:0]  rtField,
    input  logic [4:0]  rdField,
    output logic [31:0] aluResult,
    output logic [31:0] storeData,
    output logic [31:0] branchTarget,
    output logic        zero,
    output logic [4:0]  wRegEX,
    output logic [4:0]  controlEX,
    output logic        stall
);
    logic [31:0] opb, alu_res, hi_rd, lo_rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        is_md, busy;
    logic [31:0] alu_d, st_d, br_d;
    logic        zero_d;
    logic [4:0]  wreg_d, ctl_d;

    always_comb begin
        opb   = control[5] ? imm : rdData2;
        funct = imm[5:0];
        aluop = control[7:6];
        is_md = (aluop == 2'b10) && (funct[5:2] == 4'b0110);
        alu_res = rdData1 + opb;
        if (aluop == 2'b01) begin
            alu_res = rdData1 - opb;
        end else if (aluop == 2'b10) begin
            case (funct)
                6'b100010: alu_res = rdData1 - opb;
                6'b100100: alu_res = rdData1 & opb;
                6'b100101: alu_res = rdData1 | opb;
                6'b100111: alu_res = ~(rdData1 | opb);
                6'b101010: alu_res = {31'd0, $signed(rdData1) < $signed(opb)};
                6'b101011: alu_res = {31'd0, rdData1 < opb};
                6'b010000: alu_res = hi_rd;
                6'b010010: alu_res = lo_rd;
                default:   alu_res = rdData1 + opb;
            endcase
        end
    end

`ifdef EXECUTE_MULDIV_EN
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d, acc_step, prod_fix;
    logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        isdiv_q, isdiv_d, negp_q, negp_d, negr_q, negr_d;
    logic [32:0] sum33, shl33;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;

    // acc holds {partial product, multiplier} for mult, {remainder, quotient} for div
    always_comb begin
        sum33 = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        shl33 = acc_q[63:31];
        if (!isdiv_q)
            acc_step = {sum33, acc_q[31:1]};
        else if (shl33 >= {1'b0, b_q})
            acc_step = {32'(shl33 - {1'b0, b_q}), acc_q[30:0], 1'b1};
        else
            acc_step = {shl33[31:0], acc_q[30:0], 1'b0};
        prod_fix = negp_q ? -acc_step : acc_step;
    end

    always_comb begin
        sa    = ~funct[0] & rdData1[31];
        sb    = ~funct[0] & opb[31];
        mag_a = sa ? -rdData1 : rdData1;
        mag_b = sb ? -opb : opb;
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        isdiv_d = isdiv_q;
        negp_d  = negp_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (is_md) begin
                state_d = BUSY;
                cnt_d   = 5'd0;
                acc_d   = {32'd0, mag_a};
                b_d     = mag_b;
                isdiv_d = funct[1];
                // divide by zero keeps the all-ones quotient unsigned
                negp_d  = (sa ^ sb) && !(funct[1] && mag_b == 32'd0);
                negr_d  = sa;
            end
            BUSY: begin
                cnt_d = cnt_q + 5'd1;
                acc_d = acc_step;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                    if (isdiv_q) begin
                        lo_d = negp_q ? -acc_step[31:0] : acc_step[31:0];
                        hi_d = negr_q ? -acc_step[63:32] : acc_step[63:32];
                    end else begin
                        lo_d = prod_fix[31:0];
                        hi_d = prod_fix[63:32];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            b_q     <= 32'd0;
            isdiv_q <= 1'b0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            isdiv_q <= isdiv_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign hi_rd = hi_q;
    assign lo_rd = lo_q;
`else
    assign busy  = 1'b0;
    assign hi_rd = 32'd0;
    assign lo_rd = 32'd0;
`endif

    assign stall = busy;

    always_comb begin
        alu_d  = alu_res;
        zero_d = (alu_res == 32'd0);
        st_d   = rdData2;
        br_d   = PCnextID + {imm[29:0], 2'b00};
        wreg_d = control[8] ? rdField : rtField;
        ctl_d  = control[4:0];
        if (busy) begin
            alu_d  = 32'd0;
            zero_d = 1'b0;
            st_d   = 32'd0;
            br_d   = 32'd0;
            wreg_d = 5'd0;
            ctl_d  = 5'd0;
        end else if (is_md) begin
`ifdef EXECUTE_MULDIV_EN
            alu_d    = 32'd0;
            zero_d   = 1'b1;
            ctl_d[1] = 1'b0;
`else
            alu_d  = 32'd0;
            zero_d = 1'b0;
            st_d   = 32'd0;
            br_d   = 32'd0;
            wreg_d = 5'd0;
            ctl_d  = 5'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aluResult    <= 32'd0;
            storeData    <= 32'd0;
            branchTarget <= 32'd0;
            zero         <= 1'b0;
            wRegEX       <= 5'd0;
            controlEX    <= 5'd0;
        end else begin
            aluResult    <= alu_d;
            storeData    <= st_d;
            branchTarget <= br_d;
            zero         <= zero_d;
            wRegEX       <= wreg_d;
            controlEX    <= ctl_d;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a behavioural model.
// Exercises the multiply/divide path when EXECUTE_MULDIV_EN is defined, else its disabled behaviour.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rdData1, rdData2, imm, PCnextID;
    logic [8:0]  control;
    logic [4:0]  rtField, rdField;
    logic [31:0] aluResult, storeData, branchTarget;
    logic        zero, stall;
    logic [4:0]  wRegEX, controlEX;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    localparam logic [8:0] RTYPE = 9'b110000010;

    execute_stage dut (
        .clk(clk), .rst(rst), .rdData1(rdData1), .rdData2(rdData2), .imm(imm),
        .control(control), .PCnextID(PCnextID), .rtField(rtField), .rdField(rdField),
        .aluResult(aluResult), .storeData(storeData), .branchTarget(branchTarget),
        .zero(zero), .wRegEX(wRegEX), .controlEX(controlEX), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [8:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] pc,
                          input logic [4:0] rt, input logic [4:0] rd);
        control = c; rdData1 = a; rdData2 = b; imm = im; PCnextID = pc;
        rtField = rt; rdField = rd;
    endtask

    // Spec-level ALU behaviour
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f)
            6'd34: return a - b;
            6'd36: return a & b;
            6'd37: return a | b;
            6'd39: return ~(a | b);
            6'd42: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            6'd43: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            6'd16: return m_hi;
            6'd18: return m_lo;
            default: return a + b;
        endcase
    endfunction

    task automatic test_reset;
        set_in(RTYPE, $urandom, $urandom, 32'd32, $urandom, 5'd3, 5'd4);
        rst = 1'b1;
        cyc; cyc;
        checks++;
        if ({aluResult, storeData, branchTarget, zero, wRegEX, controlEX, stall} !== 108'd0) begin
            errors++;
            $display("FAIL reset_outputs act=%h exp=0",
                     {aluResult, storeData, branchTarget, zero, wRegEX, controlEX, stall});
        end
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_directed;
        set_in(RTYPE, 32'd5, 32'd7, 32'd32, 32'd0, 5'd3, 5'd9);
        cyc;
        checks++;
        if ({aluResult, controlEX, wRegEX} !== {32'd12, 5'b00010, 5'd9}) begin
            errors++;
            $display("FAIL rtype_add act=%h/%b/%0d exp=c/00010/9", aluResult, controlEX, wRegEX);
        end
        set_in(9'b001010000, 32'd3, 32'd3, 32'd4, 32'h100, 5'd1, 5'd2);
        cyc;
        checks++;
        if ({zero, branchTarget} !== {1'b1, 32'h110}) begin
            errors++;
            $display("FAIL beq act=%b/%h exp=1/110", zero, branchTarget);
        end
        set_in(RTYPE, 32'hFFFFFFFF, 32'd1, 32'd42, 32'd0, 5'd1, 5'd2);
        cyc;
        checks++;
        if (aluResult !== 32'd1) begin
            errors++;
            $display("FAIL slt act=%h exp=1", aluResult);
        end
        set_in(RTYPE, 32'hFFFFFFFF, 32'd1, 32'd43, 32'd0, 5'd1, 5'd2);
        cyc;
        checks++;
        if (aluResult !== 32'd0) begin
            errors++;
            $display("FAIL sltu act=%h exp=0", aluResult);
        end
    endtask

    task automatic test_random_alu(input int n);
        logic [5:0] fl [9] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd43, 6'd16, 6'd18};
        logic [8:0]  c;
        logic [31:0] a, b, im, pc, ob, r;
        logic [4:0]  rt, rd;
        logic [107:0] exp_v, act_v;
        for (int i = 0; i < n; i++) begin
            c = 9'($urandom); a = $urandom; b = $urandom; pc = $urandom;
            rt = 5'($urandom); rd = 5'($urandom);
            im = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) ? 16'hFFFF : 16'h0, 16'($urandom)} : $urandom;
            if ($urandom_range(0, 1) == 1) im[5:0] = fl[$urandom_range(0, 8)];
            if ($urandom_range(0, 4) == 0) b = a;
            if (c[7:6] == 2'b10 && im[5:2] == 4'b0110) im[5:0] = 6'd32;
            set_in(c, a, b, im, pc, rt, rd);
            ob = c[5] ? im : b;
            r  = ref_alu(c[7:6], im[5:0], a, ob);
            exp_v = {r, r == 32'd0, b, pc + im * 4, c[8] ? rd : rt, c[4:0], 1'b0};
            cyc;
            act_v = {aluResult, zero, storeData, branchTarget, wRegEX, controlEX, stall};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rand_alu[%0d] ctl=%b f=%0d act=%h exp=%h", i, c, im[5:0], act_v, exp_v);
            end
        end
    endtask

`ifdef EXECUTE_MULDIV_EN
    task automatic md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l);
        longint p, sa, sb;
        logic [63:0] u;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        case (f[1:0])
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
            2'b10: if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                   else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
            default: if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                     else begin h = a % b; l = a / b; end
        endcase
    endtask

    task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        logic bub_ok;
        set_in(RTYPE, a, b, {26'd0, f}, 32'd0, 5'd6, 5'd5);
        cyc;
        checks++;
        if (stall !== 1'b1 || controlEX[1] !== 1'b0) begin
            errors++;
            $display("FAIL %s_issue stall=%b ctl=%b exp stall=1 RegWrite=0", nm, stall, controlEX);
        end
        set_in(RTYPE, $urandom, $urandom, 32'd16, 32'd0, 5'd1, 5'd7);
        n = 0; bub_ok = 1'b1;
        while (stall === 1'b1 && n < 40) begin
            cyc; n++;
            if ({aluResult, controlEX, wRegEX} !== 42'd0) bub_ok = 1'b0;
        end
        checks++;
        if (n != 32 || !bub_ok) begin
            errors++;
            $display("FAIL %s_busy stall_cycles=%0d bubbles_ok=%b exp 32/1", nm, n, bub_ok);
        end
        m_hi = eh; m_lo = el;
        cyc;
        checks++;
        if (aluResult !== eh) begin
            errors++;
            $display("FAIL %s_mfhi act=%h exp=%h", nm, aluResult, eh);
        end
        set_in(RTYPE, 32'd0, 32'd0, 32'd18, 32'd0, 5'd1, 5'd7);
        cyc;
        checks++;
        if (aluResult !== el) begin
            errors++;
            $display("FAIL %s_mflo act=%h exp=%h", nm, aluResult, el);
        end
    endtask

    task automatic test_muldiv;
        logic [31:0] a, b, h, l;
        logic [5:0] f;
        run_md("mult_dir", 6'd24, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_md("divu_zero", 6'd27, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_md("div_dir", 6'd26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        for (int i = 0; i < 8; i++) begin
            f = 6'd24 + 6'(i % 4);
            a = $urandom;
            b = (i >= 4) ? 32'($urandom_range(1, 1000)) * (($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd1) : $urandom;
            md_model(f, a, b, h, l);
            run_md("md_rand", f, a, b, h, l);
        end
    endtask

    task automatic test_abort;
        set_in(RTYPE, 32'd123, 32'd456, 32'd24, 32'd0, 5'd6, 5'd5);
        cyc;
        for (int i = 0; i < 10; i++) cyc;
        rst = 1'b1;
        cyc;
        checks++;
        if ({stall, aluResult, storeData, branchTarget, zero, wRegEX, controlEX} !== 108'd0) begin
            errors++;
            $display("FAIL abort_reset stall=%b alu=%h ctl=%b", stall, aluResult, controlEX);
        end
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        set_in(RTYPE, 32'd0, 32'd0, 32'd16, 32'd0, 5'd1, 5'd7);
        cyc;
        checks++;
        if (aluResult !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_mfhi act=%h stall=%b exp=0/0", aluResult, stall);
        end
    endtask
`else
    task automatic test_muldiv;
        for (int f = 24; f < 28; f++) begin
            set_in(RTYPE, $urandom, $urandom_range(1, 99), 32'(f), $urandom, 5'd6, 5'd5);
            cyc;
            checks++;
            if ({aluResult, controlEX, wRegEX, stall} !== 43'd0) begin
                errors++;
                $display("FAIL md_disabled f=%0d alu=%h ctl=%b wreg=%0d stall=%b exp all 0",
                         f, aluResult, controlEX, wRegEX, stall);
            end
        end
        set_in(RTYPE, 32'd1, 32'd2, 32'd16, 32'd0, 5'd1, 5'd7);
        cyc;
        checks++;
        if ({aluResult, controlEX} !== {32'd0, 5'b00010}) begin
            errors++;
            $display("FAIL mfhi_disabled act=%h/%b exp=0/00010", aluResult, controlEX);
        end
    endtask

    task automatic test_abort;
        rst = 1'b1;
        cyc;
        checks++;
        if ({stall, aluResult, controlEX} !== 38'd0) begin
            errors++;
            $display("FAIL abort_reset stall=%b alu=%h ctl=%b", stall, aluResult, controlEX);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_in(9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        test_reset;
        test_directed;
        test_random_alu(250);
        test_muldiv;
        test_random_alu(150);
        test_abort;
        test_random_alu(50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
